// File: rtl/seq_multi_adder.sv
// rtl/seq_multi_adder.sv - sequential multi-operand adder for the Gaussian filter kernel sum
//
// Accumulates NUM_TERMS unsigned WIDTH-bit operands, taken one per in_valid/in_ready
// handshake, and presents the full-precision sum (SUM_W bits) on out_valid/out_ready.
// Build option: define MULTI_ADDER_NORM_EN to round-half-up the result by >> SHIFT.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data holds an operand
//   in_ready   out  operand can be accepted (registered)
//   in_data    in   WIDTH-bit unsigned operand
//   out_valid  out  out_sum holds a result (registered)
//   out_ready  in   downstream takes the result
//   out_sum    out  SUM_W-bit unsigned result (registered)

module seq_multi_adder #(
    parameter  int WIDTH     = 8,
    parameter  int NUM_TERMS = 9,
    parameter  int SHIFT     = 4,
    localparam int SUM_W     = WIDTH + $clog2(NUM_TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum
);

    localparam int CNT_W = ($clog2(NUM_TERMS + 1) > 1) ? $clog2(NUM_TERMS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1) begin : g_bad_width
        $error("seq_multi_adder: WIDTH must be >= 1");
    end
    if (NUM_TERMS < 1) begin : g_bad_terms
        $error("seq_multi_adder: NUM_TERMS must be >= 1");
    end
    if (SHIFT < 0 || SHIFT >= SUM_W) begin : g_bad_shift
        $error("seq_multi_adder: SHIFT must be in 0..SUM_W-1");
    end

    logic [1:0]       state_q,     state_d;
    logic [SUM_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] out_sum_q,   out_sum_d;
    logic             in_ready_q,  in_ready_d;

    logic             accept;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] result;

    assign accept = in_valid && in_ready_q;

    // In IDLE the accumulator is logically empty, so the running sum starts from zero
    // there; this also covers the NUM_TERMS==1 case where IDLE goes straight to DONE.
    assign sum = ((state_q == ST_IDLE) ? '0 : acc_q) + SUM_W'(in_data);

`ifdef MULTI_ADDER_NORM_EN
    // Round half up: add 2^(SHIFT-1) one bit wider than the sum so it cannot wrap.
    localparam logic [SUM_W:0] RND =
        (SHIFT > 0) ? ((SUM_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic [SUM_W:0] rounded;

    assign rounded = {1'b0, sum} + RND;
    assign result  = SUM_W'(rounded >> SHIFT);
`else
    assign result = sum;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d = SUM_W'(in_data);
                    cnt_d = CNT_W'(1);
                    if (NUM_TERMS == 1) begin
                        out_sum_d   = result;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end

            ST_ACCUM: begin
                if (accept) begin
                    if (cnt_q == LAST_CNT) begin
                        out_sum_d   = result;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // Result is held until downstream takes it; no new operand overlaps.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_seq_multi_adder.sv
// tb/tb_seq_multi_adder.sv - self-checking bench for seq_multi_adder

module tb_seq_multi_adder;

    localparam int SHIFT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Nine-term instance (default configuration)
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_data;
    logic [11:0] out_sum;

    // Single-term instance
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0]  in_data1;
    logic [7:0]  out_sum1;

    seq_multi_adder #(.WIDTH(8), .NUM_TERMS(9), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    seq_multi_adder #(.WIDTH(8), .NUM_TERMS(1), .SHIFT(SHIFT)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] ops [9];
        int         gmin;
        int         gmax;
        int         stall;
        bit         hammer;
        int         exp_raw;
    } vec_t;

    vec_t tbl [5];

    // Expected output for a raw kernel sum, from the rounding rule in plain arithmetic.
    function automatic int expect_sum(input int raw);
`ifdef MULTI_ADDER_NORM_EN
        return (raw + ((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0)) >> SHIFT;
`else
        return raw;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Presents one operand after 'gap' idle cycles and waits for it to be taken.
    // Entered and left at a falling edge.
    task automatic push(input logic [7:0] v, input int gap);
        bit got;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = v;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (in_ready === 1'b1) got = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL push_timeout: operand %0d not accepted, in_ready=%b", v, in_ready);
        end
    endtask

    // Feeds nine operands, then checks result timing, hold under back-pressure and release.
    task automatic run_sum(input string name, input logic [7:0] ops [9], input int gmin,
                           input int gmax, input int stall, input bit hammer, input int exp_raw);
        int exp_v;
        exp_v = expect_sum(exp_raw);
        out_ready = (stall == 0);
        for (int i = 0; i < 9; i++)
            push(ops[i], (i == 0) ? 0 : int'($urandom_range(gmax, gmin)));
        check($sformatf("%s.valid", name), {31'd0, out_valid}, 32'd1);
        check($sformatf("%s.sum", name), {20'd0, out_sum}, exp_v);
        check($sformatf("%s.in_ready_low", name), {31'd0, in_ready}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            if (hammer) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end
            @(negedge clk);
            check($sformatf("%s.hold_valid[%0d]", name, s), {31'd0, out_valid}, 32'd1);
            check($sformatf("%s.hold_sum[%0d]", name, s), {20'd0, out_sum}, exp_v);
            check($sformatf("%s.hold_ready[%0d]", name, s), {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("%s.released_valid", name), {31'd0, out_valid}, 32'd0);
        check($sformatf("%s.released_ready", name), {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rops [9];
        int         rsum;

        tbl[0].ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        tbl[0].gmin = 0; tbl[0].gmax = 0; tbl[0].stall = 0; tbl[0].hammer = 0; tbl[0].exp_raw = 45;
        tbl[1].ops = '{default: 8'd255};
        tbl[1].gmin = 0; tbl[1].gmax = 0; tbl[1].stall = 5; tbl[1].hammer = 1; tbl[1].exp_raw = 2295;
        tbl[2].ops = '{8'd3, 8'd0, 8'd7, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd9};
        tbl[2].gmin = 1; tbl[2].gmax = 3; tbl[2].stall = 0; tbl[2].hammer = 0; tbl[2].exp_raw = 24;
        tbl[3].ops = '{default: 8'd16};
        tbl[3].gmin = 0; tbl[3].gmax = 1; tbl[3].stall = 2; tbl[3].hammer = 0; tbl[3].exp_raw = 144;
        tbl[4].ops = '{default: 8'd0};
        tbl[4].gmin = 0; tbl[4].gmax = 2; tbl[4].stall = 1; tbl[4].hammer = 1; tbl[4].exp_raw = 0;

        // Reset with a valid operand present: nothing may be accepted.
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'd5;
        out_ready  = 1'b1;
        in_valid1  = 1'b1;
        in_data1   = 8'd5;
        out_ready1 = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.out_sum", {20'd0, out_sum}, 32'd0);
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);
        check("reset1.out_valid", {31'd0, out_valid1}, 32'd0);
        check("reset1.in_ready", {31'd0, in_ready1}, 32'd1);

        // Table-driven vectors
        for (int t = 0; t < 5; t++)
            run_sum($sformatf("tbl%0d", t), tbl[t].ops, tbl[t].gmin, tbl[t].gmax,
                    tbl[t].stall, tbl[t].hammer, tbl[t].exp_raw);

        // Reset in the middle of a sum discards the partial 200.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'd50, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset.out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset.out_sum", {20'd0, out_sum}, 32'd0);
        check("midreset.in_ready", {31'd0, in_ready}, 32'd1);
        rops = '{default: 8'd10};
        run_sum("after_reset", rops, 0, 0, 0, 0, 90);

        // Randomized sums against a plain-arithmetic reference
        for (int r = 0; r < 15; r++) begin
            rsum = 0;
            for (int i = 0; i < 9; i++) begin
                rops[i] = 8'($urandom_range(255, 0));
                rsum += int'(rops[i]);
            end
            run_sum($sformatf("rand%0d", r), rops, 0, 3, int'($urandom_range(4, 0)),
                    bit'($urandom_range(1, 0)), rsum);
        end

        // Single-term instance: result the cycle after the only accept.
        foreach (rops[i]) rops[i] = 8'd0;
        for (int k = 0; k < 2; k++) begin
            logic [7:0] v;
            v = (k == 0) ? 8'd8 : 8'd255;
            in_valid1 = 1'b1;
            in_data1  = v;
            @(negedge clk);
            in_valid1 = 1'b0;
            check($sformatf("one%0d.valid", k), {31'd0, out_valid1}, 32'd1);
            check($sformatf("one%0d.sum", k), {24'd0, out_sum1}, expect_sum(int'(v)));
            check($sformatf("one%0d.in_ready_low", k), {31'd0, in_ready1}, 32'd0);
            @(negedge clk);
            check($sformatf("one%0d.hold_sum", k), {24'd0, out_sum1}, expect_sum(int'(v)));
            out_ready1 = 1'b1;
            @(negedge clk);
            out_ready1 = 1'b0;
            check($sformatf("one%0d.released_valid", k), {31'd0, out_valid1}, 32'd0);
            check($sformatf("one%0d.released_ready", k), {31'd0, in_ready1}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
